// File: rtl/lcd_stream_ctrl.sv
// RGB565 stream-to-parallel-LCD timing controller: free-running h/v timing, frame-aligned start/stop, underflow flag.
// Optional colour-bar generator with a TestMode input when LCD_STREAM_TESTPAT_EN is defined.
module lcd_stream_ctrl #(
    parameter int H_PULSE  = 4,
    parameter int H_BP     = 43,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 8,
    parameter int V_PULSE  = 4,
    parameter int V_BP     = 12,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 8
) (
    input  logic        PixelClk,
    input  logic        RST,
`ifdef LCD_STREAM_TESTPAT_EN
    input  logic        TestMode,
`endif
    input  logic        Enable,
    input  logic        PIX_VALID,
    input  logic [15:0] PIX_DATA,
    output logic        PIX_READY,
    output logic        SOF,
    input  logic        CLR_ERR,
    output logic        UNDERFLOW,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic [4:0]  LCD_R,
    output logic [5:0]  LCD_G,
    output logic [4:0]  LCD_B
);

    localparam logic [15:0] H_TOTAL     = 16'(H_PULSE + H_BP + H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END  = 16'(H_PULSE);
    localparam logic [15:0] H_ACT_START = 16'(H_PULSE + H_BP);
    localparam logic [15:0] H_ACT_END   = 16'(H_PULSE + H_BP + H_ACTIVE);
    localparam logic [15:0] V_TOTAL     = 16'(V_PULSE + V_BP + V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END  = 16'(V_PULSE);
    localparam logic [15:0] V_ACT_START = 16'(V_PULSE + V_BP);
    localparam logic [15:0] V_ACT_END   = 16'(V_PULSE + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, STREAM, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] h_q, h_d, v_q, v_d;
    logic [15:0] rgb_q, rgb_d;
    logic        sof_q, sof_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        underflow_q, underflow_d;
    logic        h_last, v_last, streaming, in_active, pix_ready;

    always_comb begin
        h_last    = (h_q == H_TOTAL - 16'd1);
        v_last    = (v_q == V_TOTAL - 16'd1);
        streaming = (state_q == STREAM) || (state_q == DRAIN);
        in_active = (h_q >= H_ACT_START) && (h_q < H_ACT_END) &&
                    (v_q >= V_ACT_START) && (v_q < V_ACT_END);
    end

`ifdef LCD_STREAM_TESTPAT_EN
    localparam logic [15:0] BAR_W = (H_ACTIVE / 8 < 1) ? 16'd1 : 16'(H_ACTIVE / 8);

    logic [15:0] bar_x, bar_idx, bar_rgb;

    always_comb begin
        bar_x   = h_q - H_ACT_START;
        bar_idx = bar_x / BAR_W;
        // Any remainder pixels past the eighth bar fall into the black bar.
        case (bar_idx)
            16'd0:   bar_rgb = 16'hFFFF;
            16'd1:   bar_rgb = 16'hFFE0;
            16'd2:   bar_rgb = 16'h07FF;
            16'd3:   bar_rgb = 16'h07E0;
            16'd4:   bar_rgb = 16'hF81F;
            16'd5:   bar_rgb = 16'hF800;
            16'd6:   bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
    end

    assign pix_ready = streaming && in_active && !TestMode;
`else
    assign pix_ready = streaming && in_active;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (Enable) state_d = WAIT_SOF;
            WAIT_SOF: if (h_q == 16'd0 && v_q == 16'd0) state_d = STREAM;
            STREAM:   if (!Enable) state_d = DRAIN;
            DRAIN:    if (h_last && v_last) state_d = Enable ? STREAM : IDLE;
            default:  state_d = IDLE;
        endcase

        if (state_q == IDLE) begin
            h_d = 16'd0;
            v_d = 16'd0;
        end else begin
            h_d = h_last ? 16'd0 : h_q + 16'd1;
            v_d = v_q;
            if (h_last) v_d = v_last ? 16'd0 : v_q + 16'd1;
        end

        // SOF is registered by looking one cycle ahead at the next counter/state values.
        sof_d   = (state_d != IDLE) && (h_d == 16'd0) && (v_d == 16'd0);
        hsync_d = !((state_q != IDLE) && (h_q < H_SYNC_END));
        vsync_d = !((state_q != IDLE) && (v_q < V_SYNC_END));
        de_d    = streaming && in_active;

        rgb_d = 16'h0000;
        if (pix_ready && PIX_VALID) rgb_d = PIX_DATA;
`ifdef LCD_STREAM_TESTPAT_EN
        if (TestMode && streaming && in_active) rgb_d = bar_rgb;
`endif

        underflow_d = underflow_q;
        if (pix_ready && !PIX_VALID) underflow_d = 1'b1;
        else if (CLR_ERR)            underflow_d = 1'b0;
    end

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            h_q         <= 16'd0;
            v_q         <= 16'd0;
            rgb_q       <= 16'h0000;
            sof_q       <= 1'b0;
            de_q        <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            rgb_q       <= rgb_d;
            sof_q       <= sof_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

    assign PIX_READY = pix_ready;
    assign SOF       = sof_q;
    assign UNDERFLOW = underflow_q;
    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hsync_q;
    assign LCD_VSYNC = vsync_q;
    assign LCD_R     = rgb_q[15:11];
    assign LCD_G     = rgb_q[10:5];
    assign LCD_B     = rgb_q[4:0];

endmodule

// File: doc/lcd_stream_ctrl.md
LCD_STREAM_CTRL -- requirements
Module: lcd_stream_ctrl

Interface
REQ-001 Parameter H_PULSE, default 4, HSYNC low width in pixels.
REQ-002 Parameter H_BP, default 43, pixels between HSYNC end and first active pixel.
REQ-003 Parameter H_ACTIVE, default 480, active pixels per line.
REQ-004 Parameter H_FP, default 8, pixels after last active pixel; H_TOTAL = H_PULSE+H_BP+H_ACTIVE+H_FP = 535.
REQ-005 Parameter V_PULSE / V_BP / V_ACTIVE / V_FP, defaults 4 / 12 / 272 / 8, same meaning in lines; V_TOTAL = 296.
REQ-006 PixelClk  input  1  pixel clock; the only clock.
REQ-007 RST  input  1  reset, asynchronous, active-high.
REQ-008 Enable  input  1  request to run frames.
REQ-009 PIX_VALID  input  1  source has a pixel on PIX_DATA.
REQ-010 PIX_DATA  input  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B.
REQ-011 PIX_READY  output  1  controller consumes PIX_DATA this cycle.
REQ-012 SOF  output  1  one-cycle pulse at the start of every streamed frame.
REQ-013 CLR_ERR  input  1  clears UNDERFLOW.
REQ-014 UNDERFLOW  output  1  sticky flag: a pixel was required and none was available.
REQ-015 LCD_DE, LCD_HSYNC, LCD_VSYNC  output  1 each  panel timing; both syncs active-low.
REQ-016 LCD_R / LCD_G / LCD_B  output  5 / 6 / 5  panel colour.

Function
REQ-017 The h counter SHALL count 0..H_TOTAL-1 and wrap to 0; the v counter SHALL increment on every h wrap and wrap 0..V_TOTAL-1; both are 16 bit.
REQ-018 FSM states: IDLE, WAIT_SOF, STREAM, DRAIN.
REQ-019 IDLE: counters held at 0, all syncs high, DE low, RGB 0; Enable=1 -> WAIT_SOF.
REQ-020 WAIT_SOF: counters free-run; on h=0,v=0 -> STREAM with SOF pulse in that same cycle.
REQ-021 STREAM: Enable=0 -> DRAIN; the current frame completes normally.
REQ-022 DRAIN: on the last cycle of the frame (h=H_TOTAL-1, v=V_TOTAL-1) -> IDLE if Enable=0, else remain streaming (STREAM, with SOF on the next h=0,v=0).
REQ-023 Active region: h in [H_PULSE+H_BP, H_PULSE+H_BP+H_ACTIVE) and v in [V_PULSE+V_BP, V_PULSE+V_BP+V_ACTIVE).
REQ-024 PIX_READY SHALL be combinational; high iff state is STREAM or DRAIN and the counters are in the active region.
REQ-025 A pixel transfers when PIX_VALID and PIX_READY are both high; PIX_VALID SHALL be ignored otherwise.
REQ-026 All LCD_* outputs SHALL be registered with one cycle of latency from the counter state.
  - HSYNC low iff h<H_PULSE.
  - VSYNC low iff v<V_PULSE.
  - DE high iff PIX_READY was high in the previous cycle.
REQ-027 The RGB outputs SHALL carry the transferred pixel; when DE is low they SHALL be 0.
REQ-028 Underflow: if PIX_READY=1 and PIX_VALID=0, DE stays high, RGB=0 for that pixel, and UNDERFLOW is set on the next edge; no pixel is owed later, and timing never stalls.
REQ-029 UNDERFLOW SHALL clear on CLR_ERR=1 unless a new underflow occurs in the same cycle; set wins.
REQ-030 Syncs SHALL toggle in WAIT_SOF/STREAM/DRAIN even while no pixels flow.

Reset
REQ-031 When RST is asserted: state=IDLE, h=v=0, HSYNC=VSYNC=1, DE=0, RGB=0, SOF=0, PIX_READY=0, UNDERFLOW=0; all take effect immediately, independent of PixelClk.
REQ-032 RST asserted mid-frame SHALL abort the frame; after release the block requires a fresh WAIT_SOF.

Configuration
REQ-033 Macro LCD_STREAM_TESTPAT_EN defined: adds input TestMode (1 bit).
  - TestMode=1 in STREAM/DRAIN: PIX_READY is forced 0, the pixel input is ignored, and UNDERFLOW is not set.
  - Pattern: active pixels show 8 vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
REQ-034 Macro undefined: no TestMode port, no pattern logic.

Verification
REQ-035 Reset release with Enable=1 and PIX_VALID tied 1 -> SOF pulses once per 535*296 cycles; exactly 480*272 PIX_READY cycles per frame.
REQ-036 Default parameters -> HSYNC low for 4 cycles per 535-cycle line and VSYNC low for 4 lines; DE rises 47 cycles after the HSYNC falling edge, plus the 1-cycle output latency.
REQ-037 Pixel 16'hF81F presented on the first active pixel -> next cycle LCD_R=5'h1F, LCD_G=0, LCD_B=5'h1F, DE=1.
REQ-038 PIX_VALID dropped for 3 active cycles -> 3 black DE pixels, UNDERFLOW=1; CLR_ERR pulse -> UNDERFLOW=0.
REQ-039 Enable dropped at v=100 -> frame finishes to v=295,h=534, then IDLE; no further SOF; syncs held high.
REQ-040 RST pulsed mid-line -> all outputs reset immediately; re-enable -> SOF only at the next h=0,v=0.
